// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register write-back queue: default widths,
// producer identifiers and the queue entry type used by register-file readers.
package reg_writeback_queue_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_ADDR_WIDTH  = 5;
    localparam int DEFAULT_QUEUE_DEPTH = 4;

    typedef enum logic {
        PROD0 = 1'b0,
        PROD1 = 1'b1
    } prod_id_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic prod_id_t other_prod(input prod_id_t p);
        return (p == PROD0) ? PROD1 : PROD0;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter: combinational grant/ready plus the
// rr_ptr flop that names the preferred producer when both request.
module wb_rr_arbiter
    import reg_writeback_queue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic can_accept,
    output logic ready0,
    output logic ready1,
    output logic grant,
    output logic xfer
);

    prod_id_t rr_ptr_q;
    prod_id_t rr_ptr_d;
    prod_id_t grant_id;

    always_comb begin
        grant_id = rr_ptr_q;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr_q;
        end else if (req1_valid) begin
            grant_id = PROD1;
        end else if (req0_valid) begin
            grant_id = PROD0;
        end

        // Any valid requester holds the grant, so a transfer needs only space.
        xfer     = can_accept && (req0_valid || req1_valid);
        rr_ptr_d = xfer ? other_prod(grant_id) : rr_ptr_q;
    end

    assign ready0 = can_accept && (grant_id == PROD0);
    assign ready1 = can_accept && (grant_id == PROD1);
    assign grant  = (grant_id == PROD1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= PROD0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Two-producer register write-back queue feeding a single register-file write port.
// Optional pending-write lookup enabled by defining RF_WB_LOOKUP_EN.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [ADDR_WIDTH-1:0]        req0_addr,
    input  logic [DATA_WIDTH-1:0]        req0_data,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [ADDR_WIDTH-1:0]        req1_addr,
    input  logic [DATA_WIDTH-1:0]        req1_data,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic                         write_en,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         busy,
    input  logic [ADDR_WIDTH-1:0]        chk_addr,
    output logic                         chk_hit,
    output logic [DATA_WIDTH-1:0]        chk_data
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_addr_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_d [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [QUEUE_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic                  can_accept;
    logic                  grant;
    logic                  enq;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;

    // Acceptance looks only at the registered count, never at this cycle's pop.
    assign can_accept = (count_q < CNT_W'(QUEUE_DEPTH));
    assign pop        = (count_q != '0);

    wb_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .can_accept (can_accept),
        .ready0     (req0_ready),
        .ready1     (req1_ready),
        .grant      (grant),
        .xfer       (enq)
    );

    assign enq_addr = grant ? req1_addr : req0_addr;
    assign enq_data = grant ? req1_data : req0_data;

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (enq) begin
            mem_addr_d[wr_ptr_q] = enq_addr;
            mem_data_d[wr_ptr_q] = enq_data;
        end

        wr_ptr_d = enq ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        write_en_d   = pop;
        write_addr_d = pop ? mem_addr_q[rd_ptr_q] : write_addr_q;
        write_data_d = pop ? mem_data_q[rd_ptr_q] : write_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign count      = count_q;
    assign busy       = (count_q != '0) || write_en_q;

`ifdef RF_WB_LOOKUP_EN
    logic                  lk_hit;
    logic [DATA_WIDTH-1:0] lk_data;
    logic [PTR_W-1:0]      lk_idx;

    // Scan oldest to youngest so the last match leaves the youngest value.
    always_comb begin
        lk_idx  = '0;
        lk_hit  = write_en_q && (write_addr_q == chk_addr);
        lk_data = lk_hit ? write_data_q : '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            lk_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_addr_q[lk_idx] == chk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = mem_data_q[lk_idx];
            end
        end
    end

    assign chk_hit  = lk_hit;
    assign chk_data = lk_data;
`else
    logic unused_chk_addr;
    assign unused_chk_addr = ^chk_addr;
    assign chk_hit         = 1'b0;
    assign chk_data        = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a queue-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_reg_writeback_queue;
    import reg_writeback_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef RF_WB_LOOKUP_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic [4:0]  write_addr;
    logic [15:0] write_data;
    logic        write_en;
    logic [2:0]  count;
    logic        busy;
    logic [4:0]  chk_addr = '0;
    logic        chk_hit;
    logic [15:0] chk_data;

    int vectors = 0;
    int errors  = 0;

    reg_writeback_queue dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .count(count), .busy(busy),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending entries as a plain queue plus the write-port contents.
    wb_entry_t   mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [15:0] m_wd = '0;
    logic        m_rr = 1'b0;
    logic [15:0] exp_rf [32];
    logic [15:0] rf [32];
    wb_entry_t   wlog[$];
    int          glog[$];
    wb_entry_t   q0[$], q1[$];

    initial begin
        for (int i = 0; i < 32; i++) begin
            exp_rf[i] = '0;
            rf[i]     = '0;
        end
    end

    always @(posedge clk or posedge rst) begin : model
        int        sz;
        logic      acc, win;
        wb_entry_t e;
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_rr = 1'b0;
        end else begin
            sz  = mq.size();
            acc = (sz < DEPTH) && (req0_valid || req1_valid);
            win = (req0_valid && req1_valid) ? m_rr : req1_valid;
            m_we = 1'b0;
            if (sz > 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_wa = e.addr; m_wd = e.data;
            end
            if (acc) begin
                e.addr = win ? req1_addr : req0_addr;
                e.data = win ? req1_data : req0_data;
                mq.push_back(e);
                m_rr = ~win;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        eh;
        logic [15:0] ed;
        if (!rst) begin
            check("count", 32'(count), 32'(mq.size()));
            check("write_en", 32'(write_en), 32'(m_we));
            check("write_addr", 32'(write_addr), 32'(m_wa));
            check("write_data", 32'(write_data), 32'(m_wd));
            check("busy", 32'(busy), 32'((mq.size() != 0) || m_we));
            if (req0_valid)
                check("req0_ready", 32'(req0_ready), 32'((mq.size() < DEPTH) && (!req1_valid || m_rr == 1'b0)));
            if (req1_valid)
                check("req1_ready", 32'(req1_ready), 32'((mq.size() < DEPTH) && (!req0_valid || m_rr == 1'b1)));
            eh = 1'b0; ed = '0;
            if (m_we && m_wa == chk_addr) begin eh = 1'b1; ed = m_wd; end
            foreach (mq[i]) if (mq[i].addr == chk_addr) begin eh = 1'b1; ed = mq[i].data; end
            if (!LK) begin eh = 1'b0; ed = '0; end
            check("chk_hit", 32'(chk_hit), 32'(eh));
            check("chk_data", 32'(chk_data), 32'(ed));
            if (m_we) exp_rf[m_wa] = m_wd;
            if (write_en) begin
                rf[write_addr] = write_data;
                wlog.push_back('{addr: write_addr, data: write_data});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present queued items with valid/ready handshakes; logs the producer of each transfer.
    task automatic run_queues(input int max_cycles, input int cmax);
        int        cyc;
        logic      t0, t1;
        wb_entry_t tmp;
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < max_cycles) begin
            req0_valid = (q0.size() > 0);
            req1_valid = (q1.size() > 0);
            if (q0.size() > 0) begin req0_addr = q0[0].addr; req0_data = q0[0].data; end
            if (q1.size() > 0) begin req1_addr = q1[0].addr; req1_data = q1[0].data; end
            @(negedge clk);
            t0 = req0_valid && req0_ready;
            t1 = req1_valid && req1_ready;
            check("single_transfer", 32'(t0 && t1), 32'd0);
            check("count_bound", 32'(count <= 3'(cmax)), 32'd1);
            tick();
            if (t0) begin tmp = q0.pop_front(); glog.push_back(0); end
            if (t1) begin tmp = q1.pop_front(); glog.push_back(1); end
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("stream_timeout", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin tick(); n++; end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // single write, latency and register-file contents
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 16'h00A5;
        tick();
        req0_valid = 1'b0;
        check("lat_count1", 32'(count), 32'd1);
        check("lat_we0", 32'(write_en), 32'd0);
        tick();
        check("lat_we1", 32'(write_en), 32'd1);
        check("lat_addr", 32'(write_addr), 32'd3);
        check("lat_data", 32'(write_data), 32'h00A5);
        check("lat_count0", 32'(count), 32'd0);
        tick();
        check("lat_we_pulse", 32'(write_en), 32'd0);
        check("lat_hold_addr", 32'(write_addr), 32'd3);
        check("rf3", 32'(rf[3]), 32'h00A5);

        // alternating grants with both producers streaming
        pulse_reset();
        wlog.delete(); glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{addr: 5'(2*i), data: 16'h1000 | 16'(2*i)});
            q1.push_back('{addr: 5'(2*i+1), data: 16'h2000 | 16'(2*i+1)});
        end
        run_queues(40, 1);
        wait_idle(20);
        check("rr_grants_n", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) check("rr_grant", 32'(glog[i]), 32'(i % 2));
        check("rr_writes_n", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            check("rr_wr_addr", 32'(wlog[i].addr), 32'(i));
            check("rr_wr_data", 32'(wlog[i].data), 32'(((i % 2) ? 16'h2000 : 16'h1000) | 16'(i)));
        end

        // five back-to-back requests, order preserved
        wlog.delete();
        for (int i = 0; i < 5; i++) q0.push_back('{addr: 5'(20+i), data: 16'h3000 + 16'(i)});
        run_queues(40, DEPTH);
        wait_idle(20);
        check("burst_writes_n", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            check("burst_addr", 32'(wlog[i].addr), 32'(20+i));
            check("burst_data", 32'(wlog[i].data), 32'h3000 + 32'(i));
        end

        // same-address writes; youngest pending value wins the lookup
        chk_addr = 5'd9;
        q1.push_back('{addr: 5'd9, data: 16'h1111});
        q1.push_back('{addr: 5'd9, data: 16'h2222});
        run_queues(10, 1);
        check("young_hit", 32'(chk_hit), 32'(LK));
        check("young_data", 32'(chk_data), LK ? 32'h2222 : 32'h0);
        wait_idle(20);
        check("rf9", 32'(rf[9]), 32'h2222);

        // lookup hit and miss
        chk_addr = 5'd12;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 16'h0BEE;
        tick();
        req0_valid = 1'b0;
        check("lk_hit12", 32'(chk_hit), 32'(LK));
        check("lk_data12", 32'(chk_data), LK ? 32'h0BEE : 32'h0);
        chk_addr = 5'd13;
        #1;
        check("lk_miss13", 32'(chk_hit), 32'd0);
        chk_addr = 5'd12;
        tick();
        check("lk_hit_port", 32'(chk_hit), 32'(LK));
        wait_idle(20);

        // asynchronous reset with writes in flight
        wlog.delete();
        for (int i = 0; i < 3; i++) q0.push_back('{addr: 5'(16+i), data: 16'h4000 + 16'(i)});
        run_queues(10, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_write_en", 32'(write_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_write_addr", 32'(write_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (n < 6) begin tick(); n++; end
        check("arst_writes_n", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) check("arst_first", 32'(wlog[0].addr), 32'd16);
        check("arst_rf17", 32'(rf[17]), 32'd0);
        check("arst_rf18", 32'(rf[18]), 32'd0);

        for (int i = 0; i < 32; i++) check("rf_final", 32'(rf[i]), 32'(exp_rf[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
